mac_requant_drain: RTL

Downstream drain stage for the 8×8 DSP48E1 MAC column. It accepts the 48-bit P stream, sums P beats over one dot product (terminated by `p_last`), and requantizes the int32-clamped sum to int8 using a scale multiply, rounding shift, ReLU, zero-point add and saturation. Results are buffered in a 4-entry FIFO behind a valid/ready handshake toward the activation writeback path.

---
 rtl/tpu_requant_pkg.sv | 21 ++
 rtl/requant_fifo.sv | 53 +++++
 rtl/mac_requant_drain.sv | 134 +++++++++++++
 3 files changed

// File: rtl/tpu_requant_pkg.sv
// Shared types and constants for the MAC drain / requantization path.
// Holds datapath widths, clamp limits and the per-dot-product config bundle.
package tpu_requant_pkg;

  localparam int ACC_W  = 48;
  localparam int SUM_W  = 32;
  localparam int PROD_W = 49;

  localparam int INT8_MIN  = -128;
  localparam int INT8_MAX  = 127;
  localparam int INT32_MAX = 2147483647;
  localparam int INT32_MIN = -2147483647 - 1;

  typedef struct packed {
    logic [15:0]       scale;
    logic [5:0]        shift;
    logic signed [7:0] zero_point;
    logic              relu_en;
  } rq_cfg_t;

endpackage

// File: rtl/requant_fifo.sv
// Result FIFO with a registered head: entries land in memory, then move
// into out_data/out_valid. Ports: push/push_data in, pop/out_* out, count.
module requant_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RSTA,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count
);
  import tpu_requant_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   mem_cnt;
  logic          take;

  // Head refills whenever it is empty or being consumed.
  assign take  = (mem_cnt != '0) && (!out_valid || pop);
  assign count = mem_cnt + {{AW{1'b0}}, out_valid};

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (take) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(take);
    end
  end

endmodule

// File: rtl/mac_requant_drain.sv
// Drains the DSP P stream: sums beats per dot product, requantizes to int8.
// Ports: p_* beat handshake in, scale/shift/zero_point/relu_en, out_* FIFO.
module mac_requant_drain #(
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 48
) (
  input  logic                    CLK,
  input  logic                    RSTA,
  input  logic signed [ACC_W-1:0] p_in,
  input  logic                    p_valid,
  input  logic                    p_last,
  output logic                    p_ready,
  input  logic [15:0]             scale,
  input  logic [5:0]              shift,
  input  logic signed [7:0]       zero_point,
  input  logic                    relu_en,
  output logic signed [7:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sat_sticky
);
  import tpu_requant_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  s1_sum;
  logic                     first;
  logic                     s1_valid;
  logic                     s2_valid;
  rq_cfg_t                  cfg_in;
  rq_cfg_t                  s1_cfg;
  rq_cfg_t                  s2_cfg;
  logic signed [SUM_W-1:0]  s32;
  logic                     clamp32;
  logic signed [PROD_W-1:0] prod1;
  logic signed [PROD_W-1:0] s2_prod;
  logic signed [PROD_W-1:0] rnd;
  logic signed [PROD_W-1:0] r_add;
  logic signed [PROD_W-1:0] r_shr;
  logic signed [PROD_W-1:0] r_relu;
  logic signed [PROD_W:0]   r_zp;
  logic [7:0]               q8;
  logic                     clamp8;
  logic [CW-1:0]            fifo_count;
  logic [7:0]               fifo_q;
  logic                     p_fire;

  // Credit covers everything between the accept point and the consumer.
  assign p_ready = (int'(fifo_count) + int'(s1_valid) + int'(s2_valid))
                   < FIFO_DEPTH;
  assign p_fire   = p_valid && p_ready;
  assign acc_next = (first ? '0 : acc) + p_in;
  assign cfg_in   = '{scale, shift, zero_point, relu_en};
  assign out_data = $signed(fifo_q);

  always_comb begin
    s32     = s1_sum[SUM_W-1:0];
    clamp32 = 1'b0;
    if (s1_sum > ACC_W'(INT32_MAX)) begin
      s32     = INT32_MAX;
      clamp32 = 1'b1;
    end else if (s1_sum < ACC_W'(INT32_MIN)) begin
      s32     = INT32_MIN;
      clamp32 = 1'b1;
    end
    prod1 = PROD_W'(s32) * PROD_W'($signed({1'b0, s1_cfg.scale}));
  end

  always_comb begin
    rnd = '0;
    if (s2_cfg.shift != '0)
      rnd = PROD_W'(1) << (s2_cfg.shift - 6'd1);
    r_add  = s2_prod + rnd;
    r_shr  = r_add >>> s2_cfg.shift;
    r_relu = (s2_cfg.relu_en && r_shr[PROD_W-1]) ? '0 : r_shr;
    r_zp   = (PROD_W+1)'(r_relu) + (PROD_W+1)'(s2_cfg.zero_point);
    q8     = r_zp[7:0];
    clamp8 = 1'b0;
    if (r_zp > (PROD_W+1)'(INT8_MAX)) begin
      q8     = 8'(INT8_MAX);
      clamp8 = 1'b1;
    end else if (r_zp < (PROD_W+1)'(INT8_MIN)) begin
      q8     = 8'(INT8_MIN);
      clamp8 = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      acc        <= '0;
      first      <= 1'b1;
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_cfg     <= '0;
      s2_valid   <= 1'b0;
      s2_prod    <= '0;
      s2_cfg     <= '0;
      sat_sticky <= 1'b0;
    end else begin
      s1_valid <= p_fire && p_last;
      s2_valid <= s1_valid;
      if (p_fire) begin
        acc   <= acc_next;
        first <= p_last;
      end
      if (p_fire && p_last) begin
        s1_sum <= acc_next;
        s1_cfg <= cfg_in;
      end
      if (s1_valid) begin
        s2_prod <= prod1;
        s2_cfg  <= s1_cfg;
      end
      if ((s1_valid && clamp32) || (s2_valid && clamp8))
        sat_sticky <= 1'b1;
    end
  end

  requant_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RSTA      (RSTA),
    .push      (s2_valid),
    .push_data (q8),
    .pop       (out_ready),
    .out_data  (fifo_q),
    .out_valid (out_valid),
    .count     (fifo_count)
  );

endmodule
